mul_final_cpa: RTL and testbench

//  Final carry-propagate stage of the vector/scalar multiplier. Consumes the

---
 rtl/mul_final_cpa.sv | 119 +++++++++++
 tb/tb_mul_final_cpa.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_final_cpa.sv
// Final carry-propagate adder of the multiplier: adds the redundant sum/carry
// pair in two registered halves and returns the selected product half with its tag.
module mul_final_cpa #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*XLEN-1:0] in_sum,
  input  logic [2*XLEN-1:0] in_carry,
  input  logic [1:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam logic [1:0] OP_MUL = 2'b00;

  // Handshake: a transfer happens on a cycle where valid and ready are both high;
  // a stage advances when it is empty or its successor advances this cycle.
  logic s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] s1_lo_q, s1_lo_d;
  logic s1_c_q, s1_c_d;
  logic [XLEN-1:0] s1_sum_hi_q, s1_sum_hi_d;
  logic [XLEN-1:0] s1_carry_hi_q, s1_carry_hi_d;
  logic [1:0] s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_result_q, s2_result_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic s1_adv, s2_adv, in_xfer, s1_move;
  logic [XLEN:0] lo_sum;
  logic [XLEN-1:0] hi_sum;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv & ~flush;
  assign in_xfer  = in_valid & in_ready;
  assign s1_move  = s1_valid_q & s2_adv;

  assign lo_sum = {1'b0, in_sum[XLEN-1:0]} + {1'b0, in_carry[XLEN-1:0]};
  // Carry-out of the high half is dropped: the product is exactly 2*XLEN bits.
  assign hi_sum = s1_sum_hi_q + s1_carry_hi_q + {{(XLEN-1){1'b0}}, s1_c_q};

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_lo_d       = s1_lo_q;
    s1_c_d        = s1_c_q;
    s1_sum_hi_d   = s1_sum_hi_q;
    s1_carry_hi_d = s1_carry_hi_q;
    s1_op_d       = s1_op_q;
    s1_tag_d      = s1_tag_q;
    s2_valid_d    = s2_valid_q;
    s2_result_d   = s2_result_q;
    s2_tag_d      = s2_tag_q;

    if (s1_adv) s1_valid_d = in_xfer;
    if (in_xfer) begin
      s1_lo_d       = lo_sum[XLEN-1:0];
      s1_c_d        = lo_sum[XLEN];
      s1_sum_hi_d   = in_sum[2*XLEN-1:XLEN];
      s1_carry_hi_d = in_carry[2*XLEN-1:XLEN];
      s1_op_d       = in_op;
      s1_tag_d      = in_tag;
    end

    if (s2_adv) s2_valid_d = s1_valid_q;
    // Data only loads behind a valid op, so held outputs never change under stall.
    if (s1_move) begin
      s2_result_d = (s1_op_q == OP_MUL) ? s1_lo_q : hi_sum;
      s2_tag_d    = s1_tag_q;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_lo_q       <= '0;
      s1_c_q        <= 1'b0;
      s1_sum_hi_q   <= '0;
      s1_carry_hi_q <= '0;
      s1_op_q       <= '0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      s2_tag_q      <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_lo_q       <= s1_lo_d;
      s1_c_q        <= s1_c_d;
      s1_sum_hi_q   <= s1_sum_hi_d;
      s1_carry_hi_q <= s1_carry_hi_d;
      s1_op_q       <= s1_op_d;
      s1_tag_q      <= s1_tag_d;
      s2_valid_q    <= s2_valid_d;
      s2_result_q   <= s2_result_d;
      s2_tag_q      <= s2_tag_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_tag    = s2_tag_q;
  assign busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_mul_final_cpa.sv
// Directed bench for mul_final_cpa: drives and samples on the falling edge,
// checks each point with an immediate assertion.
module tb_mul_final_cpa;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_sum;
  logic [63:0] in_carry;
  logic [1:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int checks;
  int errors;
  logic [31:0] exp_q[$];
  logic [4:0]  tag_q[$];

  mul_final_cpa #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full-width 64-bit add, then pick the half.
  function automatic logic [31:0] model(input logic [63:0] s, input logic [63:0] c,
                                        input logic [1:0] op);
    logic [63:0] full;
    full = s + c;
    return (op == 2'b00) ? full[31:0] : full[63:32];
  endfunction

  task automatic drive(input logic v, input logic [63:0] s, input logic [63:0] c,
                       input logic [1:0] op, input logic [4:0] tag);
    in_valid = v;
    in_sum   = s;
    in_carry = c;
    in_op    = op;
    in_tag   = tag;
  endtask

  // One isolated op with out_ready high; expected value given by hand.
  task automatic single(input string name, input logic [63:0] s, input logic [63:0] c,
                        input logic [1:0] op, input logic [4:0] tag, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, s, c, op, tag);
    check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    drive(1'b0, '0, '0, 2'b00, 5'd0);
    check({name, "_busy1"}, {63'd0, busy}, 64'd1);
    check({name, "_early_valid"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({name, "_result"}, {32'd0, out_result}, {32'd0, exp});
    check({name, "_tag"}, {59'd0, out_tag}, {59'd0, tag});
    @(negedge clk);
    check({name, "_drained"}, {62'd0, out_valid, busy}, 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 2'b00, 5'd0);

    // reset state
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", {32'd0, out_result}, 64'd0);
    check("rst_tag", {59'd0, out_tag}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // carry crossing halves, wrap, plain add
    single("t1_mul", 64'h00000000_FFFFFFFF, 64'h1, 2'b00, 5'd1, 32'h00000000);
    single("t1_mulh", 64'h00000000_FFFFFFFF, 64'h1, 2'b01, 5'd2, 32'h00000001);
    single("t2_wrap", 64'hFFFFFFFF_FFFFFFFF, 64'h1, 2'b11, 5'd3, 32'h00000000);
    single("t2_mul", 64'h12345678_9ABCDEF0, 64'h11111111_11111111, 2'b00, 5'd4, 32'hABCDF001);
    single("t2_mulh", 64'h12345678_9ABCDEF0, 64'h11111111_11111111, 2'b01, 5'd5, 32'h23456789);
    single("t2_mulhsu", 64'h7FFFFFFF_80000000, 64'h00000001_80000000, 2'b10, 5'd6, 32'h80000001);

    // ten back-to-back ops at full rate
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      check($sformatf("t3_valid_c%0d", cyc), {63'd0, out_valid}, {63'd0, (cyc >= 2)});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("t3_underflow", 64'd1, 64'd0);
        end else begin
          check($sformatf("t3_result_c%0d", cyc), {32'd0, out_result}, {32'd0, exp_q.pop_front()});
          check($sformatf("t3_tag_c%0d", cyc), {59'd0, out_tag}, {59'd0, tag_q.pop_front()});
        end
      end
      if (cyc < 10) begin
        logic [63:0] s, c;
        logic [31:0] iv;
        iv = 32'(cyc);
        s = {iv << 4, 32'hFFFFFFF8};
        c = {32'h00000100, iv};
        drive(1'b1, s, c, iv[1:0], iv[4:0]);
        exp_q.push_back(model(s, c, iv[1:0]));
        tag_q.push_back(iv[4:0]);
        check($sformatf("t3_in_ready_c%0d", cyc), {63'd0, in_ready}, 64'd1);
      end else begin
        drive(1'b0, '0, '0, 2'b00, 5'd0);
      end
    end
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // stall: two accepted, third refused until release
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 64'h00000002_00000003, 64'h00000010_00000020, 2'b00, 5'd10);
    check("t4_rdy_a", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    drive(1'b1, 64'h00000002_00000003, 64'h00000010_00000020, 2'b01, 5'd11);
    check("t4_rdy_b", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    drive(1'b1, 64'h00000005_FFFFFFFF, 64'h00000006_00000002, 2'b11, 5'd12);
    check("t4_rdy_c_blocked", {63'd0, in_ready}, 64'd0);
    check("t4_hold_valid", {63'd0, out_valid}, 64'd1);
    check("t4_hold_result0", {32'd0, out_result}, 64'h00000023);
    check("t4_hold_tag0", {59'd0, out_tag}, 64'd10);
    @(negedge clk);
    check("t4_rdy_c_still", {63'd0, in_ready}, 64'd0);
    check("t4_hold_result1", {32'd0, out_result}, 64'h00000023);
    check("t4_hold_tag1", {59'd0, out_tag}, 64'd10);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("t4_release_rdy", {63'd0, in_ready}, 64'd1);
    check("t4_out0", {32'd0, out_result}, 64'h00000023);
    @(negedge clk);
    drive(1'b0, '0, '0, 2'b00, 5'd0);
    check("t4_out1_valid", {63'd0, out_valid}, 64'd1);
    check("t4_out1", {32'd0, out_result}, 64'h00000012);
    check("t4_out1_tag", {59'd0, out_tag}, 64'd11);
    @(negedge clk);
    check("t4_out2", {32'd0, out_result}, 64'h0000000C);
    check("t4_out2_tag", {59'd0, out_tag}, 64'd12);
    @(negedge clk);
    check("t4_drained", {62'd0, out_valid, busy}, 64'd0);

    // flush with both stages full and an op offered
    out_ready = 1'b0;
    drive(1'b1, 64'h1, 64'h1, 2'b00, 5'd20);
    @(negedge clk);
    drive(1'b1, 64'h2, 64'h2, 2'b00, 5'd21);
    @(negedge clk);
    drive(1'b1, 64'h3, 64'h3, 2'b00, 5'd22);
    flush = 1'b1;
    #1;
    check("t5_busy_before", {63'd0, busy}, 64'd1);
    check("t5_in_ready_flush", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, '0, '0, 2'b00, 5'd0);
    check("t5_busy_after", {63'd0, busy}, 64'd0);
    check("t5_valid_after", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("t5_not_accepted", {62'd0, out_valid, busy}, 64'd0);
    out_ready = 1'b1;
    single("t5_post", 64'h0000000A_80000000, 64'h00000005_80000000, 2'b01, 5'd23, 32'h00000010);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 64'h4, 64'h4, 2'b00, 5'd24);
    @(negedge clk);
    drive(1'b1, 64'h5, 64'h5, 2'b00, 5'd25);
    @(negedge clk);
    drive(1'b0, '0, '0, 2'b00, 5'd0);
    check("t6_valid_pre", {63'd0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", {63'd0, out_valid}, 64'd0);
    check("t6_async_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t6_in_ready", {63'd0, in_ready}, 64'd1);
    check("t6_empty", {62'd0, out_valid, busy}, 64'd0);
    single("t6_post", 64'h00000001_00000001, 64'h00000002_FFFFFFFF, 2'b00, 5'd26, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
